cbus_arbiter: RTL and testbench



---
 rtl/cbus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cbus_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// cbus_pkg: CBus request/response payload types shared by masters, arbiter and bridge.
// cbus_arbiter: round-robin arbiter sharing one downstream CBus port among NUM_REQ masters.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   ireqs      upstream requests, index 0 has the highest priority out of reset
//   iresps     upstream responses, only the granted master sees oresp
//   oreq       downstream request, the granted master's request while busy
//   oresp      downstream response
//   busy       a transaction is currently granted
//   grant_idx  index of the current or most recently granted master
package cbus_pkg;

  localparam int unsigned CBUS_ADDR_W = 32;
  localparam int unsigned CBUS_DATA_W = 32;
  localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;
  localparam int unsigned CBUS_SIZE_W = 3;
  localparam int unsigned CBUS_LEN_W  = 8;
  localparam int unsigned CBUS_BRST_W = 2;

  localparam logic [CBUS_BRST_W-1:0] CBUS_BURST_FIXED = 2'd0;
  localparam logic [CBUS_BRST_W-1:0] CBUS_BURST_INCR  = 2'd1;

  localparam logic [CBUS_SIZE_W-1:0] CBUS_MSIZE1 = 3'd0;
  localparam logic [CBUS_SIZE_W-1:0] CBUS_MSIZE2 = 3'd1;
  localparam logic [CBUS_SIZE_W-1:0] CBUS_MSIZE4 = 3'd2;
  localparam logic [CBUS_SIZE_W-1:0] CBUS_MSIZE8 = 3'd3;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_DATA_W-1:0] data;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_SIZE_W-1:0] size;
    logic [CBUS_LEN_W-1:0]  len;
    logic [CBUS_BRST_W-1:0] burst;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
    logic                   err;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_REQ],
  output cbus_resp_t       iresps [NUM_REQ],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e             state_q,     state_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   prio_q,      prio_d;

  logic [NUM_REQ-1:0] req_vld;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               txn_done;

  // (base + off) mod NUM_REQ, valid for non-power-of-two NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                              input int unsigned      off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Gather valid bits so the scan indexes a flat vector.
  always_comb begin
    req_vld = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vld[i] = ireqs[i].valid;
    end
  end

  // Round-robin scan starting at prio_q; first valid wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_vld[rr_idx(prio_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx(prio_q, k);
      end
    end
  end

  assign txn_done = oresp.ready && oresp.last;

  // Next-state: grant only from IDLE, release only on the final accepted beat.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    prio_d      = prio_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (txn_done) begin
          state_d = S_IDLE;
          prio_d  = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                         : grant_idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      grant_idx_q <= '0;
      prio_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      prio_q      <= prio_d;
    end
  end

  // Data path: only the registered grant steers the request/response muxes.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      iresps[i] = '0;
    end
    if (state_q == S_BUSY) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_idx_q == IDX_W'(i)) begin
          oreq      = ireqs[i];
          iresps[i] = oresp;
        end
      end
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: directed scenarios on a 2-master and a 3-master instance,
// plus randomized traffic on the 2-master instance against a transaction-level model.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  cbus_req_t  ir2 [2];
  cbus_resp_t rs2 [2];
  cbus_req_t  or2;
  cbus_resp_t orsp2;
  logic       busy2;
  logic [0:0] g2;

  cbus_req_t  ir3 [3];
  cbus_resp_t rs3 [3];
  cbus_req_t  or3;
  cbus_resp_t orsp3;
  logic       busy3;
  logic [1:0] g3;

  int checks = 0;
  int errors = 0;

  // Model of the 2-master instance: grant/priority plus downstream beat count.
  int m_busy, m_gidx, m_prio, m_beat;

  cbus_arbiter #(.NUM_REQ(2)) dut2 (
    .clk(clk), .reset(reset), .ireqs(ir2), .iresps(rs2),
    .oreq(or2), .oresp(orsp2), .busy(busy2), .grant_idx(g2)
  );

  cbus_arbiter #(.NUM_REQ(3)) dut3 (
    .clk(clk), .reset(reset), .ireqs(ir3), .iresps(rs3),
    .oreq(or3), .oresp(orsp3), .busy(busy3), .grant_idx(g3)
  );

  function automatic cbus_req_t mk_req(input bit wr, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [7:0] len);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.addr     = addr;
    r.data     = data;
    r.strobe   = wr ? 4'hf : 4'h0;
    r.size     = CBUS_MSIZE4;
    r.len      = len;
    r.burst    = (len == 8'd0) ? CBUS_BURST_FIXED : CBUS_BURST_INCR;
    return r;
  endfunction

  // One clock: advance the model from inputs present at the edge, end on the falling edge.
  task automatic step();
    int nb, ng, np, nbt;
    nb = m_busy; ng = m_gidx; np = m_prio; nbt = m_beat;
    if (m_busy == 0) begin
      for (int k = 0; k < N2; k++) begin
        if (nb == 0 && ir2[(m_prio + k) % N2].valid) begin
          nb = 1; ng = (m_prio + k) % N2; nbt = 0;
        end
      end
    end else if (orsp2.ready) begin
      if (orsp2.last) begin
        nb = 0; np = (m_gidx + 1) % N2; nbt = 0;
      end else begin
        nbt = m_beat + 1;
      end
    end
    @(posedge clk);
    if (reset) begin
      m_busy = nb; m_gidx = ng; m_prio = np; m_beat = nbt;
    end else begin
      m_busy = 0; m_gidx = 0; m_prio = 0; m_beat = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) ir2[i] = mk_req(1'b0, 32'h1000 + 32'(i), 32'h0, 8'd0);
    for (int i = 0; i < 3; i++) ir3[i] = mk_req(1'b0, 32'h2000 + 32'(i), 32'h0, 8'd0);
    orsp2 = '0; orsp3 = '0;
    step(); step();
    checks++;
    if (or2.valid !== 1'b0 || busy2 !== 1'b0 || g2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got valid=%0b busy=%0b gidx=%0d want 0 0 0", or2.valid, busy2, g2);
    end
    checks++;
    if (rs2[0] !== '0 || rs2[1] !== '0) begin
      errors++;
      $display("FAIL reset_iresps got %h %h want 0", rs2[0], rs2[1]);
    end
    checks++;
    if (dut2.prio_q !== 1'b0 || busy3 !== 1'b0 || g3 !== 2'd0 || or3.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_misc got prio=%0d busy3=%0b g3=%0d want 0", dut2.prio_q, busy3, g3);
    end
    for (int i = 0; i < 3; i++) ir3[i].valid = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if (busy2 !== 1'b1 || g2 !== 1'b0 || or2 !== ir2[0]) begin
      errors++;
      $display("FAIL reset_first_grant got busy=%0b gidx=%0d want busy=1 gidx=0", busy2, g2);
    end
    ir2[0].valid = 1'b0; ir2[1].valid = 1'b0;
    orsp2.ready = 1'b1; orsp2.last = 1'b1;
    step();
    orsp2 = '0;
    #1;
    checks++;
    if (busy2 !== 1'b0 || 32'(dut2.prio_q) !== 32'(m_prio) || m_prio != 1) begin
      errors++;
      $display("FAIL reset_release got busy=%0b prio=%0d want busy=0 prio=1", busy2, dut2.prio_q);
    end
  endtask

  task automatic test_single();
    ir2[1] = mk_req(1'b0, 32'h8000_0010, 32'h0, 8'd0);
    orsp2 = '0; orsp2.ready = 1'b1; orsp2.last = 1'b1; orsp2.data = 32'hCAFE_0001;
    step();
    checks++;
    if (busy2 !== 1'b1 || g2 !== 1'b1 || or2.addr !== 32'h8000_0010 || or2.valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got busy=%0b gidx=%0d addr=%h want 1 1 80000010", busy2, g2, or2.addr);
    end
    checks++;
    if (rs2[1].last !== 1'b1 || rs2[1].data !== 32'hCAFE_0001 || rs2[0] !== '0) begin
      errors++;
      $display("FAIL single_resp got r1=%h r0=%h want r1.last=1 r0=0", rs2[1], rs2[0]);
    end
    ir2[1].valid = 1'b0;
    step();
    orsp2 = '0;
    #1;
    checks++;
    if (busy2 !== 1'b0 || dut2.prio_q !== 1'b0 || or2.valid !== 1'b0) begin
      errors++;
      $display("FAIL single_after got busy=%0b prio=%0d want 0 0", busy2, dut2.prio_q);
    end
  endtask

  task automatic test_contention();
    int  wg;
    bit  wb;
    ir2[0] = mk_req(1'b1, 32'h100, 32'hAAAA_0000, 8'd0);
    ir2[1] = mk_req(1'b1, 32'h200, 32'hBBBB_0000, 8'd0);
    orsp2 = '0; orsp2.ready = 1'b1; orsp2.last = 1'b1; orsp2.data = 32'h1234;
    for (int s = 0; s < 8; s++) begin
      step();
      wb = (s % 2 == 0);
      wg = (s / 2) % 2;
      checks++;
      if (busy2 !== wb || (wb && g2 !== 1'(wg))) begin
        errors++;
        $display("FAIL contention_grant s=%0d got busy=%0b gidx=%0d want busy=%0b gidx=%0d", s, busy2, g2, wb, wg);
      end
      checks++;
      if (wb ? (rs2[wg] !== orsp2 || rs2[1-wg] !== '0 || or2 !== ir2[wg])
             : (rs2[0] !== '0 || rs2[1] !== '0 || or2 !== '0)) begin
        errors++;
        $display("FAIL contention_route s=%0d got oreq.data=%h r0=%h r1=%h", s, or2.data, rs2[0], rs2[1]);
      end
    end
    ir2[0].valid = 1'b0; ir2[1].valid = 1'b0;
    orsp2 = '0;
    #1;
    checks++;
    if (dut2.prio_q !== 1'b0) begin
      errors++;
      $display("FAIL contention_prio got %0d want 0", dut2.prio_q);
    end
  endtask

  task automatic test_incr();
    ir2[0] = mk_req(1'b1, 32'h300, 32'hC0, 8'd3);
    ir2[0].size = CBUS_MSIZE8;
    orsp2 = '0; orsp2.ready = 1'b1;
    step();
    for (int b = 0; b < 4; b++) begin
      orsp2.last = (b == 3);
      if (b == 1) ir2[1] = mk_req(1'b0, 32'h400, 32'h0, 8'd0);
      #1;
      checks++;
      if (busy2 !== 1'b1 || g2 !== 1'b0 || or2 !== ir2[0]) begin
        errors++;
        $display("FAIL incr_hold b=%0d got busy=%0b gidx=%0d want 1 0", b, busy2, g2);
      end
      checks++;
      if (rs2[0].last !== 1'(b == 3) || rs2[1] !== '0) begin
        errors++;
        $display("FAIL incr_resp b=%0d got last0=%0b r1=%h want last0=%0b r1=0", b, rs2[0].last, rs2[1], b == 3);
      end
      step();
    end
    ir2[0].valid = 1'b0;
    orsp2.last = 1'b1;
    #1;
    checks++;
    if (busy2 !== 1'b0 || or2.valid !== 1'b0) begin
      errors++;
      $display("FAIL incr_dead got busy=%0b valid=%0b want 0 0", busy2, or2.valid);
    end
    step();
    checks++;
    if (busy2 !== 1'b1 || g2 !== 1'b1) begin
      errors++;
      $display("FAIL incr_next got busy=%0b gidx=%0d want 1 1", busy2, g2);
    end
    ir2[1].valid = 1'b0;
    step();
    orsp2 = '0;
  endtask

  task automatic test_wrap();
    bit wb;
    int wg;
    for (int i = 0; i < 3; i++) ir3[i] = mk_req(1'b0, 32'h500 + 32'(i * 16), 32'h0, 8'd0);
    orsp3 = '0; orsp3.ready = 1'b1; orsp3.last = 1'b1;
    for (int s = 0; s < 10; s++) begin
      step();
      wb = (s % 2 == 0);
      wg = (s / 2) % 3;
      checks++;
      if (busy3 !== wb || (wb && (g3 !== 2'(wg) || or3 !== ir3[wg] || rs3[wg] !== orsp3))) begin
        errors++;
        $display("FAIL wrap_grant s=%0d got busy=%0b gidx=%0d want busy=%0b gidx=%0d", s, busy3, g3, wb, wg);
      end
      if (!wb) begin
        checks++;
        if (32'(dut3.prio_q) !== 32'((wg + 1) % 3)) begin
          errors++;
          $display("FAIL wrap_prio s=%0d got %0d want %0d", s, dut3.prio_q, (wg + 1) % 3);
        end
      end
    end
    for (int i = 0; i < 3; i++) ir3[i].valid = 1'b0;
    orsp3 = '0;
  endtask

  task automatic test_reset_mid_burst();
    ir2[0] = mk_req(1'b1, 32'h600, 32'h66, 8'd0);
    orsp2 = '0; orsp2.ready = 1'b1; orsp2.last = 1'b1;
    step(); step();
    ir2[0].valid = 1'b0;
    ir2[1] = mk_req(1'b0, 32'h680, 32'h0, 8'd7);
    orsp2.last = 1'b0;
    step(); step();
    #1;
    checks++;
    if (busy2 !== 1'b1 || g2 !== 1'b1 || or2.valid !== 1'b1 || dut2.prio_q !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got busy=%0b gidx=%0d prio=%0d want 1 1 1", busy2, g2, dut2.prio_q);
    end
    #1;
    reset = 1'b0;
    m_busy = 0; m_gidx = 0; m_prio = 0; m_beat = 0;
    #1;
    checks++;
    if (busy2 !== 1'b0 || or2.valid !== 1'b0 || g2 !== 1'b0 || dut2.prio_q !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got busy=%0b valid=%0b gidx=%0d prio=%0d want 0", busy2, or2.valid, g2, dut2.prio_q);
    end
    @(negedge clk);
    ir2[1].valid = 1'b0;
    orsp2 = '0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_stall_drop();
    ir2[1] = mk_req(1'b1, 32'h700, 32'h77, 8'd0);
    orsp2 = '0; orsp2.last = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) ir2[1].valid = 1'b0;
      #1;
      checks++;
      if (busy2 !== 1'b1 || g2 !== 1'b1 || or2.valid !== 1'(c < 2)) begin
        errors++;
        $display("FAIL stall_hold c=%0d got busy=%0b gidx=%0d valid=%0b", c, busy2, g2, or2.valid);
      end
      step();
    end
    orsp2.ready = 1'b1;
    #1;
    checks++;
    if (rs2[1].ready !== 1'b1 || rs2[1].last !== 1'b1 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL stall_final got r1=%h busy=%0b", rs2[1], busy2);
    end
    step();
    orsp2 = '0;
    #1;
    checks++;
    if (busy2 !== 1'b0 || dut2.prio_q !== 1'(m_prio) || m_prio != 0) begin
      errors++;
      $display("FAIL stall_release got busy=%0b prio=%0d want 0 0", busy2, dut2.prio_q);
    end
  endtask

  task automatic test_random();
    bit         pend [2];
    bit         done;
    int         gi;
    cbus_req_t  exp_req;
    cbus_resp_t exp_rsp;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; ir2[i] = '0;
    end
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          ir2[i]  = mk_req(1'($urandom_range(0, 1)), $urandom, $urandom, 8'($urandom_range(0, 3)));
        end
      end
      orsp2       = '0;
      orsp2.ready = ($urandom_range(0, 3) != 0);
      orsp2.data  = $urandom;
      orsp2.last  = (m_busy != 0) && orsp2.ready && (m_beat == int'(ir2[m_gidx].len));
      #1;
      exp_req = (m_busy != 0) ? ir2[m_gidx] : '0;
      checks++;
      if (busy2 !== 1'(m_busy) || (m_busy != 0 && g2 !== 1'(m_gidx)) || or2 !== exp_req) begin
        errors++;
        $display("FAIL random_req n=%0d got busy=%0b gidx=%0d addr=%h want busy=%0d gidx=%0d addr=%h",
                 n, busy2, g2, or2.addr, m_busy, m_gidx, exp_req.addr);
      end
      for (int i = 0; i < 2; i++) begin
        exp_rsp = (m_busy != 0 && m_gidx == i) ? orsp2 : '0;
        checks++;
        if (rs2[i] !== exp_rsp) begin
          errors++;
          $display("FAIL random_resp n=%0d port=%0d got %h want %h", n, i, rs2[i], exp_rsp);
        end
      end
      checks++;
      if (32'(dut2.prio_q) !== 32'(m_prio)) begin
        errors++;
        $display("FAIL random_prio n=%0d got %0d want %0d", n, dut2.prio_q, m_prio);
      end
      done = (m_busy != 0) && orsp2.ready && orsp2.last;
      gi   = m_gidx;
      step();
      if (done) begin
        pend[gi] = 1'b0; ir2[gi].valid = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) ir2[i] = '0;
    orsp2 = '0;
  endtask

  initial begin
    reset = 1'b0;
    m_busy = 0; m_gidx = 0; m_prio = 0; m_beat = 0;
    for (int i = 0; i < 2; i++) ir2[i] = '0;
    for (int i = 0; i < 3; i++) ir3[i] = '0;
    orsp2 = '0; orsp3 = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_incr();
    test_wrap();
    test_reset_mid_burst();
    test_stall_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
